// File: rtl/sha3_absorb_ctrl.sv
// SHA-3 absorb controller: turns a 64-bit message stream into rate-block lane writes,
// applies pad10*1 padding and sequences one permutation handshake per block.
module sha3_absorb_ctrl #(
    parameter int RATE_LANES = 17
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [63:0] s_tdata,
    input  logic        s_tlast,
    input  logic [2:0]  s_tuser,
    output logic        lane_we,
    output logic [4:0]  lane_addr,
    output logic [63:0] lane_data,
    output logic        blk_go,
    output logic        blk_last,
    input  logic        perm_done,
    output logic        msg_done
);

    typedef enum logic [1:0] {
        ABSORB,
        PADLANE,
        ZFILL,
        PERM
    } state_t;

    localparam logic [4:0]  LAST_LANE = 5'(RATE_LANES - 1);
    localparam logic [63:0] PAD_LANE  = 64'h0100_0000_0000_0000;
    localparam logic [63:0] END_BIT   = 64'h0000_0000_0000_0080;

    state_t      state_q, state_d;
    logic [4:0]  lane_cnt_q, lane_cnt_d;
    logic        pad_pend_q, pad_pend_d;
    logic        s_tready_q, s_tready_d;
    logic        lane_we_q, lane_we_d;
    logic [4:0]  lane_addr_q, lane_addr_d;
    logic [63:0] lane_data_q, lane_data_d;
    logic        blk_go_q, blk_go_d;
    logic        blk_last_q, blk_last_d;
    logic        msg_done_q, msg_done_d;

    logic        at_last;
    logic        accept;
    logic        perm_ok;

    // Keep the first nbytes bytes (MSB first), put the 0x01 pad byte right after them.
    function automatic logic [63:0] pad_partial(input logic [63:0] data,
                                                input logic [2:0]  nbytes);
        logic [63:0] keep;
        keep = ~(64'hFFFF_FFFF_FFFF_FFFF >> {nbytes, 3'b000});
        return (data & keep) | (PAD_LANE >> {nbytes, 3'b000});
    endfunction

    assign at_last = (lane_cnt_q == LAST_LANE);
    assign accept  = s_tvalid && s_tready_q;
    // The core's pulse only counts once blk_go has been seen by it.
    assign perm_ok = perm_done && !lane_we_q && !blk_go_q;

    always_comb begin
        // NOTE: every _d gets a default here so no path through the case infers a latch.
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        pad_pend_d  = pad_pend_q;
        lane_we_d   = 1'b0;
        lane_addr_d = lane_addr_q;
        lane_data_d = lane_data_q;
        blk_go_d    = 1'b0;
        blk_last_d  = blk_last_q;
        msg_done_d  = 1'b0;

        unique case (state_q)
            ABSORB: begin
                if (accept) begin
                    lane_we_d   = 1'b1;
                    lane_addr_d = lane_cnt_q;
                    lane_cnt_d  = at_last ? lane_cnt_q : lane_cnt_q + 5'd1;
                    if (!s_tlast) begin
                        lane_data_d = s_tdata;
                        if (at_last) begin
                            state_d    = PERM;
                            blk_last_d = 1'b0;
                        end
                    end else if (s_tuser != 3'd0) begin
                        lane_data_d = pad_partial(s_tdata, s_tuser) | (at_last ? END_BIT : 64'd0);
                        if (at_last) begin
                            state_d    = PERM;
                            blk_last_d = 1'b1;
                        end else begin
                            state_d = ZFILL;
                        end
                    end else begin
                        lane_data_d = s_tdata;
                        if (at_last) begin
                            // Full final block: permute it, then pad into a fresh block.
                            state_d    = PERM;
                            blk_last_d = 1'b0;
                            pad_pend_d = 1'b1;
                        end else begin
                            state_d = PADLANE;
                        end
                    end
                end
            end

            PADLANE, ZFILL: begin
                lane_we_d   = 1'b1;
                lane_addr_d = lane_cnt_q;
                lane_data_d = ((state_q == PADLANE) ? PAD_LANE : 64'd0) |
                              (at_last ? END_BIT : 64'd0);
                if (at_last) begin
                    state_d    = PERM;
                    blk_last_d = 1'b1;
                end else begin
                    state_d    = ZFILL;
                    lane_cnt_d = lane_cnt_q + 5'd1;
                end
            end

            PERM: begin
                blk_go_d = lane_we_q;
                if (perm_ok) begin
                    lane_cnt_d = 5'd0;
                    blk_last_d = 1'b0;
                    if (blk_last_q) begin
                        msg_done_d = 1'b1;
                        state_d    = ABSORB;
                    end else if (pad_pend_q) begin
                        pad_pend_d = 1'b0;
                        state_d    = PADLANE;
                    end else begin
                        state_d = ABSORB;
                    end
                end
            end

            default: state_d = ABSORB;
        endcase

        s_tready_d = (state_d == ABSORB);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ABSORB;
            lane_cnt_q  <= 5'd0;
            pad_pend_q  <= 1'b0;
            s_tready_q  <= 1'b0;
            lane_we_q   <= 1'b0;
            lane_addr_q <= 5'd0;
            lane_data_q <= 64'd0;
            blk_go_q    <= 1'b0;
            blk_last_q  <= 1'b0;
            msg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            pad_pend_q  <= pad_pend_d;
            s_tready_q  <= s_tready_d;
            lane_we_q   <= lane_we_d;
            lane_addr_q <= lane_addr_d;
            lane_data_q <= lane_data_d;
            blk_go_q    <= blk_go_d;
            blk_last_q  <= blk_last_d;
            msg_done_q  <= msg_done_d;
        end
    end

    assign s_tready  = s_tready_q;
    assign lane_we   = lane_we_q;
    assign lane_addr = lane_addr_q;
    assign lane_data = lane_data_q;
    assign blk_go    = blk_go_q;
    assign blk_last  = blk_last_q;
    assign msg_done  = msg_done_q;

endmodule
